// File: rtl/bp_pkg.sv
// bp_pkg: shared index/tag extraction and saturating counter helpers for the branch predictor
package bp_pkg;
  function automatic int idx_bits(input int entries);
    return $clog2(entries);
  endfunction
  function automatic logic [63:0] pc_index(input logic [63:0] pc);
    return pc >> 2;
  endfunction
  function automatic logic [63:0] pc_tag(input logic [63:0] pc, input int ib);
    return pc >> (ib + 2);
  endfunction
  function automatic logic [7:0] sat_update(input logic [7:0] ctr, input logic taken, input int bits);
    logic [7:0] top;
    top = 8'((9'd1 << bits) - 9'd1);
    return taken ? (ctr == top ? ctr : ctr + 8'd1) : (ctr == 8'd0 ? ctr : ctr - 8'd1);
  endfunction
endpackage

// File: rtl/bp_table.sv
// bp_table: branch target buffer storage with fetch read port, update probe/write port and reset valid-clear
module bp_table #(
  parameter int XLEN = 32,
  parameter int ENTRIES = 16,
  parameter int IDX_BITS = 4,
  parameter int TAG_BITS = 8,
  parameter int CTR_BITS = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [IDX_BITS-1:0] a_idx,
  output logic                a_valid,
  output logic [TAG_BITS-1:0] a_tag,
  output logic [XLEN-1:0]     a_target,
  output logic                a_taken,
  input  logic [IDX_BITS-1:0] w_idx,
  output logic                b_valid,
  output logic [TAG_BITS-1:0] b_tag,
  output logic [CTR_BITS-1:0] b_ctr,
  input  logic                we,
  input  logic                tgt_we,
  input  logic                w_valid,
  input  logic [TAG_BITS-1:0] w_tag,
  input  logic [XLEN-1:0]     w_target,
  input  logic [CTR_BITS-1:0] w_ctr
);
  typedef struct packed {
    logic                valid;
    logic [TAG_BITS-1:0] tag;
    logic [XLEN-1:0]     target;
    logic [CTR_BITS-1:0] ctr;
  } entry_t;
  entry_t mem [ENTRIES];
  always_comb begin
    a_valid = mem[a_idx].valid;
    a_tag = mem[a_idx].tag;
    a_target = mem[a_idx].target;
    a_taken = mem[a_idx].ctr[CTR_BITS-1];
    b_valid = mem[w_idx].valid;
    b_tag = mem[w_idx].tag;
    b_ctr = mem[w_idx].ctr;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        mem[i].valid <= 1'b0;
        mem[i].ctr <= '0;
      end
    end else begin
      if (we) begin
        mem[w_idx].valid <= w_valid;
        mem[w_idx].tag <= w_tag;
        mem[w_idx].ctr <= w_ctr;
      end
      if (tgt_we) mem[w_idx].target <= w_target;
    end
  end
endmodule

// File: rtl/branch_predictor.sv
// branch_predictor: BTB with saturating direction counters, E-stage update, mispredict detect and stats
module branch_predictor import bp_pkg::*; #(
  parameter int XLEN = 32,
  parameter int ENTRIES = 16,
  parameter int TAG_BITS = 8,
  parameter int CTR_BITS = 2,
  parameter int STAT_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [XLEN-1:0]   pc_f,
  output logic              hit_f,
  output logic              pred_taken_f,
  output logic [XLEN-1:0]   pred_next_pc_f,
  input  logic              upd_valid_e,
  input  logic [XLEN-1:0]   upd_pc_e,
  input  logic              upd_is_branch_e,
  input  logic              upd_is_jump_e,
  input  logic              upd_taken_e,
  input  logic [XLEN-1:0]   upd_target_e,
  input  logic [XLEN-1:0]   upd_pred_next_e,
  output logic              mispredict_e,
  output logic [XLEN-1:0]   correct_pc_e,
  output logic [STAT_W-1:0] stat_ctl,
  output logic [STAT_W-1:0] stat_mis
);
  localparam int IDX_BITS = idx_bits(ENTRIES);
  localparam logic [CTR_BITS-1:0] CTR_MAX = '1;
  localparam logic [CTR_BITS-1:0] CTR_WEAK = CTR_BITS'(1 << (CTR_BITS - 1));
  logic [IDX_BITS-1:0] idx_f, idx_e;
  logic [TAG_BITS-1:0] tag_f, tag_e, a_tag, b_tag, w_tag;
  logic [XLEN-1:0] a_target;
  logic [CTR_BITS-1:0] b_ctr, w_ctr;
  logic a_valid, a_taken, b_valid, hit_e, is_jump, is_br, we, tgt_we, w_valid;
  assign idx_f = IDX_BITS'(pc_index(64'(pc_f)));
  assign tag_f = TAG_BITS'(pc_tag(64'(pc_f), IDX_BITS));
  assign idx_e = IDX_BITS'(pc_index(64'(upd_pc_e)));
  assign tag_e = TAG_BITS'(pc_tag(64'(upd_pc_e), IDX_BITS));
  bp_table #(
    .XLEN(XLEN), .ENTRIES(ENTRIES), .IDX_BITS(IDX_BITS), .TAG_BITS(TAG_BITS), .CTR_BITS(CTR_BITS)
  ) u_table (
    .clk(clk), .rst(rst),
    .a_idx(idx_f), .a_valid(a_valid), .a_tag(a_tag), .a_target(a_target), .a_taken(a_taken),
    .w_idx(idx_e), .b_valid(b_valid), .b_tag(b_tag), .b_ctr(b_ctr),
    .we(we), .tgt_we(tgt_we), .w_valid(w_valid), .w_tag(w_tag), .w_target(upd_target_e), .w_ctr(w_ctr)
  );
  always_comb begin
    hit_f = a_valid && a_tag == tag_f;
    pred_taken_f = hit_f && a_taken;
    pred_next_pc_f = pred_taken_f ? a_target : pc_f + XLEN'(4);
    correct_pc_e = upd_taken_e ? upd_target_e : upd_pc_e + XLEN'(4);
    mispredict_e = upd_valid_e && upd_pred_next_e != correct_pc_e;
    hit_e = b_valid && b_tag == tag_e;
    is_jump = upd_is_jump_e;
    is_br = upd_is_branch_e && !upd_is_jump_e;
    we = upd_valid_e && (is_jump || (is_br && (hit_e || upd_taken_e)) || (!is_br && !is_jump && hit_e));
    tgt_we = upd_valid_e && (is_jump || (is_br && upd_taken_e));
    w_valid = is_jump || is_br;
    w_tag = tag_e;
    w_ctr = is_jump ? CTR_MAX : !is_br ? '0 : hit_e ? CTR_BITS'(sat_update(8'(b_ctr), upd_taken_e, CTR_BITS)) : CTR_WEAK;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_ctl <= '0;
      stat_mis <= '0;
    end else begin
      if (upd_valid_e && (upd_is_branch_e || upd_is_jump_e) && stat_ctl != '1) stat_ctl <= stat_ctl + STAT_W'(1);
      if (mispredict_e && stat_mis != '1) stat_mis <= stat_mis + STAT_W'(1);
    end
  end
endmodule
